mpe_seq_ctrl: RTL and testbench

Sequencer that drives one `matrix_pe` through a complete output computation per command. It accepts a command (uop, base address, beat count) and issues the shared NRAM/WRAM read addresses. It presents each 512-bit beat to the PE with valid/ready handshakes and first/last tags, then captures the PE's 32-bit result and writes it into the result buffer at an auto-incrementing address. It sits between the instruction buffer and the `matrix_pe`/NRAM/WRAM/result-buffer cluster.

---
 rtl/mpe_seq_pkg.sv | 26 ++
 rtl/mpe_seq_wdog.sv | 25 ++
 rtl/mpe_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_mpe_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpe_seq_pkg.sv
// rtl/mpe_seq_pkg.sv - shared FSM state and beat-tag encodings for mpe_seq_ctrl
package mpe_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] CTL_FIRST = 2'b01;
  localparam logic [1:0] CTL_MID   = 2'b00;
  localparam logic [1:0] CTL_LAST  = 2'b10;
  localparam logic [1:0] CTL_ONLY  = 2'b11;

  function automatic logic [1:0] beat_tag(input logic is_first, input logic is_last);
    logic [1:0] tag;
    case ({is_last, is_first})
      2'b01:   tag = CTL_FIRST;
      2'b10:   tag = CTL_LAST;
      2'b11:   tag = CTL_ONLY;
      default: tag = CTL_MID;
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/mpe_seq_wdog.sv
// rtl/mpe_seq_wdog.sv - DRAIN watchdog: counts enabled cycles, flags expiry on cycle TIMEOUT-1
module mpe_seq_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt <= '0;
    end else if (!o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mpe_seq_ctrl.sv
// rtl/mpe_seq_ctrl.sv - per-command matrix_pe sequencer: RAM read issue, beat handshakes, result write-back
// Optional DRAIN watchdog enabled by defining MPE_SEQ_CTRL_TIMEOUT_EN.
module mpe_seq_ctrl
  import mpe_seq_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 3,
  parameter int RES_AW = 2
`ifdef MPE_SEQ_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [7:0]        i_cmd_uop,
  input  logic [ADDR_W-1:0] i_cmd_base,
  input  logic [LEN_W-1:0]  i_cmd_len,
  output logic              o_ram_rd_en,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  output logic [7:0]        o_mpe_uop,
  output logic              o_mpe_uop_valid,
  output logic              o_mpe_neuron_valid,
  output logic              o_mpe_weight_valid,
  input  logic              i_mpe_uop_ready,
  input  logic              i_mpe_neuron_ready,
  input  logic              i_mpe_weight_ready,
  output logic [1:0]        o_mpe_ctl,
  input  logic [31:0]       i_mpe_result,
  input  logic              i_mpe_vld_o,
  output logic              o_res_wr_en,
  output logic [RES_AW-1:0] o_res_wr_addr,
  output logic [31:0]       o_res_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  state_t              r_state;
  logic [7:0]          r_uop;
  logic [ADDR_W-1:0]   r_base;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W:0]      r_rd_cnt;
  logic [LEN_W-1:0]    r_fire_cnt;
  logic                r_dvld;
  logic                r_wr_en;
  logic [RES_AW-1:0]   r_wr_addr;
  logic [31:0]         r_wr_data;

  logic w_issue;
  logic w_fire;
  logic w_rd_en;
  logic w_last_fire;
  logic w_timeout;

  assign w_issue     = (r_state == ST_ISSUE);
  assign w_fire      = r_dvld && i_mpe_uop_ready && i_mpe_neuron_ready && i_mpe_weight_ready;
  // A new read is only allowed when the held beat is consumed this cycle, so RAM data stays put under stall
  assign w_rd_en     = w_issue && (r_rd_cnt <= {1'b0, r_len}) && (!r_dvld || w_fire);
  assign w_last_fire = w_fire && (r_fire_cnt == r_len);

`ifdef MPE_SEQ_CTRL_TIMEOUT_EN
  logic r_err;

  mpe_seq_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (r_state == ST_DRAIN),
    .o_expired (w_timeout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == ST_DRAIN) && !i_mpe_vld_o && w_timeout;
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_uop      <= '0;
      r_base     <= '0;
      r_len      <= '0;
      r_rd_cnt   <= '0;
      r_fire_cnt <= '0;
      r_dvld     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (r_wr_en) begin
        r_wr_addr <= r_wr_addr + RES_AW'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_uop      <= i_cmd_uop;
            r_base     <= i_cmd_base;
            r_len      <= i_cmd_len;
            r_rd_cnt   <= '0;
            r_fire_cnt <= '0;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_rd_en) begin
            r_rd_cnt <= r_rd_cnt + (LEN_W + 1)'(1);
            r_dvld   <= 1'b1;
          end else if (w_fire) begin
            r_dvld <= 1'b0;
          end
          if (w_fire) begin
            r_fire_cnt <= r_fire_cnt + LEN_W'(1);
          end
          if (w_last_fire) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (i_mpe_vld_o) begin
            r_wr_data <= i_mpe_result;
            r_wr_en   <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready        = (r_state == ST_IDLE);
  assign o_busy             = (r_state != ST_IDLE);
  assign o_ram_rd_en        = w_rd_en;
  assign o_ram_rd_addr      = r_base + ADDR_W'(r_rd_cnt);
  assign o_mpe_uop          = r_uop;
  assign o_mpe_uop_valid    = r_dvld;
  assign o_mpe_neuron_valid = r_dvld;
  assign o_mpe_weight_valid = r_dvld;
  assign o_mpe_ctl          = r_dvld ? beat_tag(r_fire_cnt == '0, r_fire_cnt == r_len) : 2'b00;
  assign o_res_wr_en        = r_wr_en;
  assign o_done             = r_wr_en;
  assign o_res_wr_addr      = r_wr_addr;
  assign o_res_wr_data      = r_wr_data;

endmodule

// File: tb/tb_mpe_seq_ctrl.sv
// tb/tb_mpe_seq_ctrl.sv - directed self-checking bench for mpe_seq_ctrl
module tb_mpe_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_uop;
  logic [3:0]  cmd_base;
  logic [2:0]  cmd_len;
  logic        ram_rd_en;
  logic [3:0]  ram_rd_addr;
  logic [7:0]  mpe_uop;
  logic        mpe_uop_valid;
  logic        mpe_neuron_valid;
  logic        mpe_weight_valid;
  logic        mpe_uop_ready;
  logic        mpe_neuron_ready;
  logic        mpe_weight_ready;
  logic [1:0]  mpe_ctl;
  logic [31:0] mpe_result;
  logic        mpe_vld_o;
  logic        res_wr_en;
  logic [1:0]  res_wr_addr;
  logic [31:0] res_wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mpe_seq_ctrl dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_cmd_valid        (cmd_valid),
    .o_cmd_ready        (cmd_ready),
    .i_cmd_uop          (cmd_uop),
    .i_cmd_base         (cmd_base),
    .i_cmd_len          (cmd_len),
    .o_ram_rd_en        (ram_rd_en),
    .o_ram_rd_addr      (ram_rd_addr),
    .o_mpe_uop          (mpe_uop),
    .o_mpe_uop_valid    (mpe_uop_valid),
    .o_mpe_neuron_valid (mpe_neuron_valid),
    .o_mpe_weight_valid (mpe_weight_valid),
    .i_mpe_uop_ready    (mpe_uop_ready),
    .i_mpe_neuron_ready (mpe_neuron_ready),
    .i_mpe_weight_ready (mpe_weight_ready),
    .o_mpe_ctl          (mpe_ctl),
    .i_mpe_result       (mpe_result),
    .i_mpe_vld_o        (mpe_vld_o),
    .o_res_wr_en        (res_wr_en),
    .o_res_wr_addr      (res_wr_addr),
    .o_res_wr_data      (res_wr_data),
    .o_busy             (busy),
    .o_done             (done),
    .o_err              (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_ctl(input int k, input int len);
    if (k == 0 && k == len) return 2'b11;
    if (k == 0)             return 2'b01;
    if (k == len)           return 2'b10;
    return 2'b00;
  endfunction

  task automatic set_ready(input logic v);
    mpe_uop_ready    = v;
    mpe_neuron_ready = v;
    mpe_weight_ready = v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_rd_en"}, 32'(ram_rd_en), 0);
    check({pfx, "_rd_addr"}, 32'(ram_rd_addr), 0);
    check({pfx, "_uop"}, 32'(mpe_uop), 0);
    check({pfx, "_valids"}, 32'({mpe_uop_valid, mpe_neuron_valid, mpe_weight_valid}), 0);
    check({pfx, "_ctl"}, 32'(mpe_ctl), 0);
    check({pfx, "_wr_en_done_err"}, 32'({res_wr_en, done, err}), 0);
    check({pfx, "_wr_addr"}, 32'(res_wr_addr), 0);
    check({pfx, "_wr_data"}, res_wr_data, 0);
  endtask

  // Runs one command through ISSUE; optionally feeds a PE result after lat idle DRAIN cycles.
  task automatic run_cmd(input logic [3:0] base, input logic [2:0] len, input logic [7:0] uop,
                         input logic [7:0] stall_beats, input logic [31:0] result,
                         input logic [1:0] exp_waddr, input int lat, input bit give_result);
    int rd_i, fire_i, cyc, stall_left, n_stalls, last_fire_cyc;
    logic [7:0] stalled;
    logic [3:0] exp_addr;
    rd_i = 0; fire_i = 0; cyc = 0; stall_left = 0; n_stalls = 0; last_fire_cyc = -1;
    stalled = '0;
    next_cycle();
    cmd_valid = 1'b1; cmd_base = base; cmd_len = len; cmd_uop = uop;
    set_ready(1'b1);
    @(negedge clk);
    check("accept_cmd_ready", 32'(cmd_ready), 1);
    check("accept_rd_en", 32'(ram_rd_en), 0);
    while (fire_i <= int'(len) && cyc < 64) begin
      next_cycle();
      cyc++;
      // A competing command during ISSUE must be ignored
      cmd_valid = (cyc == 1);
      cmd_base  = base ^ 4'hF;
      if (stall_left == 0 && mpe_neuron_valid && stall_beats[fire_i] && !stalled[fire_i]) begin
        stall_left = 2;
        stalled[fire_i] = 1'b1;
        n_stalls++;
      end
      set_ready(stall_left == 0);
      @(negedge clk);
      check("issue_busy", 32'({busy, cmd_ready}), 32'h2);
      check("issue_no_wr", 32'({res_wr_en, done}), 0);
      if (cyc == 1) begin
        check("first_rd_en", 32'(ram_rd_en), 1);
        check("first_no_valid", 32'(mpe_neuron_valid), 0);
      end
      if (ram_rd_en) begin
        exp_addr = base + 4'(rd_i);
        check("rd_addr", 32'(ram_rd_addr), 32'(exp_addr));
        rd_i++;
      end
      if (mpe_neuron_valid) begin
        check("valids", 32'({mpe_uop_valid, mpe_weight_valid}), 32'h3);
        check("ctl", 32'(mpe_ctl), 32'(exp_ctl(fire_i, int'(len))));
        check("mpe_uop", 32'(mpe_uop), 32'(uop));
        if (stall_left > 0) begin
          check("stall_no_rd", 32'(ram_rd_en), 0);
          stall_left--;
        end else begin
          fire_i++;
          last_fire_cyc = cyc;
        end
      end
    end
    cmd_valid = 1'b0;
    check("n_fires", 32'(fire_i), 32'(int'(len) + 1));
    check("n_reads", 32'(rd_i), 32'(int'(len) + 1));
    check("last_fire_cycle", 32'(last_fire_cyc), 32'(2 + int'(len) + 2 * n_stalls));
    if (give_result) begin
      for (int i = 0; i < lat; i++) begin
        next_cycle();
        @(negedge clk);
        check("drain_state", 32'({busy, cmd_ready, ram_rd_en, mpe_neuron_valid, res_wr_en}), 32'h10);
      end
      next_cycle();
      mpe_vld_o = 1'b1; mpe_result = result;
      @(negedge clk);
      check("vld_cycle_no_wr", 32'({busy, res_wr_en}), 32'h2);
      next_cycle();
      mpe_vld_o = 1'b0; mpe_result = 32'h0;
      @(negedge clk);
      check("wr_en_done", 32'({res_wr_en, done, err}), 32'h6);
      check("wr_addr", 32'(res_wr_addr), 32'(exp_waddr));
      check("wr_data", res_wr_data, result);
      check("wr_cycle_ready", 32'({cmd_ready, busy}), 32'h2);
      next_cycle();
      @(negedge clk);
      check("wr_pulse_end", 32'({res_wr_en, done}), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_uop = '0; cmd_base = '0; cmd_len = '0;
    set_ready(1'b0); mpe_result = '0; mpe_vld_o = 1'b0;
    next_cycle(); next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("por");

    // Four commands, no backpressure, results to addresses 0..3
    run_cmd(4'd0,  3'd3, 8'h11, 8'h00, 32'hC0DE_0000, 2'd0, 2, 1'b1);
    run_cmd(4'd4,  3'd3, 8'h22, 8'h00, 32'hC0DE_0001, 2'd1, 0, 1'b1);
    run_cmd(4'd8,  3'd3, 8'h33, 8'h00, 32'hC0DE_0002, 2'd2, 3, 1'b1);
    run_cmd(4'd12, 3'd3, 8'h44, 8'h00, 32'hC0DE_0003, 2'd3, 1, 1'b1);

    // Stalls on beats 1 and 3; fifth write wraps to address 0
    run_cmd(4'd2,  3'd3, 8'h55, 8'b0000_1010, 32'h1234_5678, 2'd0, 1, 1'b1);

    // Single beat command
    run_cmd(4'd5,  3'd0, 8'h66, 8'h00, 32'hFFFF_FFFF, 2'd1, 0, 1'b1);

    // Read address wrap 14,15,0,1
    run_cmd(4'd14, 3'd3, 8'h77, 8'h00, 32'h0BAD_F00D, 2'd2, 2, 1'b1);

    // Result valid while idle must not write
    next_cycle();
    mpe_vld_o = 1'b1; mpe_result = 32'hDEAD_BEEF;
    @(negedge clk);
    next_cycle();
    mpe_vld_o = 1'b0; mpe_result = 32'h0;
    @(negedge clk);
    check("idle_vld_no_wr", 32'({res_wr_en, done, busy}), 0);
    check("idle_vld_addr", 32'(res_wr_addr), 3);
    check("idle_vld_data", res_wr_data, 32'h0BAD_F00D);

    // Reset after two fires in ISSUE
    next_cycle();
    cmd_valid = 1'b1; cmd_base = 4'd0; cmd_len = 3'd3; cmd_uop = 8'h88;
    set_ready(1'b1);
    @(negedge clk);
    next_cycle();
    cmd_valid = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("pre_rst_ctl_first", 32'(mpe_ctl), 32'h1);
    next_cycle();
    @(negedge clk);
    check("pre_rst_ctl_mid", 32'(mpe_ctl), 32'h0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_cycle_busy", 32'(busy), 1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_rst");
    next_cycle();
    @(negedge clk);
    check("post_rst_no_wr", 32'({res_wr_en, busy}), 0);
    run_cmd(4'd9, 3'd1, 8'h99, 8'h00, 32'hA5A5_0001, 2'd0, 1, 1'b1);

`ifdef MPE_SEQ_CTRL_TIMEOUT_EN
    // PE never answers: err at DRAIN entry + 15, no write
    run_cmd(4'd3, 3'd1, 8'h5A, 8'h00, 32'h0, 2'd0, 0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      next_cycle();
      @(negedge clk);
      check("wdog_wait", 32'({busy, err, res_wr_en}), 32'h4);
    end
    next_cycle();
    @(negedge clk);
    check("wdog_err", 32'({err, cmd_ready, busy, res_wr_en, done}), 32'h18);
    check("wdog_addr", 32'(res_wr_addr), 1);
    next_cycle();
    @(negedge clk);
    check("wdog_err_pulse", 32'(err), 0);
    run_cmd(4'd6, 3'd0, 8'h5B, 8'h00, 32'h7777_0000, 2'd1, 2, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
